highscore_updater: RTL and testbench

//  Controller directly upstream of the highscore BRAM (2**N slots of W-bit scores, negedge-clocked,

---
 rtl/highscore_updater.sv | 126 ++++++++++++
 tb/tb_highscore_updater.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/highscore_updater.sv
// highscore_updater: sequencer in front of a negedge-clocked highscore BRAM.
// Handles two requests. A game-over request does a read-compare-write of
// one slot, and writes only when the score is a strict new record. A clear
// request zeroes every slot. All outputs come from registers, so they stay
// stable at the BRAM's negedge sampling point.
module highscore_updater #(
  parameter int N = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         game_over,
  input  logic [W-1:0] score,
  input  logic [N-1:0] slot,
  input  logic         clear_req,
  output logic [N-1:0] ram_addr,
  output logic         ram_we,
  output logic [W-1:0] ram_wdata,
  output logic         ram_clear,
  input  logic [W-1:0] ram_rdata,
  output logic         busy,
  output logic         done,
  output logic         new_record,
  output logic [W-1:0] best_score
);

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, CMP, WR, CLR, DONE
  } state_t;

  // The clear counter is one bit wider than the address. This lets the
  // terminal compare reach the last slot without wrapping to zero.
  localparam logic [N:0] LAST_SLOT = {1'b0, {N{1'b1}}};

  state_t       state;
  logic [W-1:0] score_q;
  logic [N-1:0] slot_q;
  logic [N:0]   clr_cnt;
  logic         rec_q;

  // The BRAM has no use for its own clear input; slots are zeroed by walking them.
  assign ram_clear = 1'b0;

  // Controller FSM. Each output is registered and reflects the action of the state just left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      score_q    <= '0;
      slot_q     <= '0;
      clr_cnt    <= '0;
      rec_q      <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      new_record <= 1'b0;
      best_score <= '0;
    end else begin
      // NOTE: non-blocking defaults here turn the pulse outputs into one-cycle
      // strobes. A later assignment in the case arm overrides the default.
      ram_we     <= 1'b0;
      done       <= 1'b0;
      new_record <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            // A clear wins; a game_over that arrives in the same cycle is dropped.
            clr_cnt <= '0;
            busy    <= 1'b1;
            state   <= CLR;
          end else if (game_over) begin
            score_q <= score;
            slot_q  <= slot;
            busy    <= 1'b1;
            state   <= RD;
          end
        end
        RD: begin
          ram_addr <= slot_q;
          state    <= WAIT;
        end
        WAIT: begin
          // Give the BRAM one negedge to latch the address and a second one to register data_out.
          state <= CMP;
        end
        CMP: begin
          if (score_q > ram_rdata) begin
            best_score <= score_q;
            state      <= WR;
          end else begin
            best_score <= ram_rdata;
            state      <= DONE;
          end
        end
        WR: begin
          ram_we    <= 1'b1;
          ram_addr  <= slot_q;
          ram_wdata <= score_q;
          rec_q     <= 1'b1;
          state     <= DONE;
        end
        CLR: begin
          ram_we     <= 1'b1;
          ram_wdata  <= '0;
          ram_addr   <= clr_cnt[N-1:0];
          best_score <= '0;
          clr_cnt    <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_SLOT) state <= DONE;
        end
        DONE: begin
          done       <= 1'b1;
          new_record <= rec_q;
          rec_q      <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_highscore_updater.sv
// Testbench for highscore_updater (N=1, W=8). It contains a behavioural
// negedge BRAM model and a queue-based scoreboard of expected completions.
// A table drives the update sequence. Hand-written sequences cover the
// clear/game_over collision, a request issued while busy, and a reset
// that hits in the middle of a write.
module tb_highscore_updater;

  localparam int N = 1;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         game_over = 1'b0;
  logic [W-1:0] score = '0;
  logic [N-1:0] slot = '0;
  logic         clear_req = 1'b0;
  logic [N-1:0] ram_addr;
  logic         ram_we;
  logic [W-1:0] ram_wdata;
  logic         ram_clear;
  logic [W-1:0] ram_rdata = '0;
  logic         busy;
  logic         done;
  logic         new_record;
  logic [W-1:0] best_score;

  highscore_updater #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_over  (game_over),
    .score      (score),
    .slot       (slot),
    .clear_req  (clear_req),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_clear  (ram_clear),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .done       (done),
    .new_record (new_record),
    .best_score (best_score)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: negedge-clocked write and registered read; counts writes.
  logic [W-1:0] mem [2**N];
  int           wr_cnt = 0;
  initial for (int i = 0; i < 2**N; i++) mem[i] = '0;
  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt++;
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic         rec;
    logic [W-1:0] best;
    int           lat;
    int           writes;
  } exp_t;

  typedef struct {
    logic [N-1:0] slot;
    logic [W-1:0] score;
    logic         rec;
    logic [W-1:0] best;
  } vec_t;

  exp_t         sb [$];
  logic [W-1:0] ref_mem [2**N];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done. Then pop the scoreboard and compare.
  // If inject is set, a second game_over (slot 1, score 200) is driven while the DUT is busy.
  task automatic run_op(input logic go, input logic cl, input logic [N-1:0] s,
                        input logic [W-1:0] sc, input logic inject);
    int   w0;
    int   cnt;
    exp_t e;
    w0 = wr_cnt;
    @(negedge clk);
    game_over = go; clear_req = cl; slot = s; score = sc;
    @(posedge clk); #1;
    check("busy_after_req", busy, 1);
    @(negedge clk);
    game_over = 1'b0; clear_req = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      if (done) break;
      game_over = inject && (cnt == 1);
      if (inject && cnt == 1) begin slot = 1'b1; score = 8'd200; end
    end
    game_over = 1'b0;
    if (!done) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check("latency", cnt, e.lat);
      check("new_record", new_record, e.rec);
      check("best_score", best_score, e.best);
      check("write_count", wr_cnt - w0, e.writes);
      check("busy_at_done", busy, 0);
      for (int i = 0; i < 2**N; i++) check("slot_content", mem[i], ref_mem[i]);
    end
  endtask

  initial begin
    vec_t vecs [8];
    int   w0;
    vecs[0] = '{1'b0, 8'd50,  1'b1, 8'd50};
    vecs[1] = '{1'b1, 8'd90,  1'b1, 8'd90};
    vecs[2] = '{1'b0, 8'd72,  1'b1, 8'd72};   // 50 stored -> record 72
    vecs[3] = '{1'b1, 8'd90,  1'b0, 8'd90};   // equal score, no write
    vecs[4] = '{1'b0, 8'd254, 1'b1, 8'd254};
    vecs[5] = '{1'b0, 8'd255, 1'b1, 8'd255};  // unsigned top value
    vecs[6] = '{1'b0, 8'd0,   1'b0, 8'd255};  // 0 never beats 255
    vecs[7] = '{1'b1, 8'd89,  1'b0, 8'd90};
    for (int i = 0; i < 2**N; i++) ref_mem[i] = '0;

    // Reset state.
    #12;
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_new_record", new_record, 0);
    check("rst_best_score", best_score, 0);
    check("ram_clear_tied", ram_clear, 0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven updates.
    foreach (vecs[i]) begin
      if (vecs[i].rec) ref_mem[vecs[i].slot] = vecs[i].score;
      sb.push_back('{vecs[i].rec, vecs[i].best, vecs[i].rec ? 5 : 4, vecs[i].rec ? 1 : 0});
      run_op(1'b1, 1'b0, vecs[i].slot, vecs[i].score, 1'b0);
    end

    // Request while busy: only the first one (slot 1, score 100 beats 90) takes effect.
    ref_mem[1] = 8'd100;
    sb.push_back('{1'b1, 8'd100, 5, 1});
    run_op(1'b1, 1'b0, 1'b1, 8'd100, 1'b1);
    w0 = wr_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("ignored_busy", busy, 0);
    check("ignored_writes", wr_cnt - w0, 0);
    check("ignored_slot1", mem[1], 100);

    // Clear and game_over in the same cycle: the clear wins and the game_over is dropped.
    ref_mem[0] = '0; ref_mem[1] = '0;
    sb.push_back('{1'b0, 8'd0, 2**N + 1, 2**N});
    run_op(1'b1, 1'b1, 1'b0, 8'd180, 1'b0);
    w0 = wr_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("dropped_go_busy", busy, 0);
    check("dropped_go_writes", wr_cnt - w0, 0);

    // Reset in the middle of a write: ram_we drops at once and the slot keeps its value.
    @(negedge clk);
    game_over = 1'b1; slot = 1'b0; score = 8'd33;
    @(posedge clk); #1;
    @(negedge clk); game_over = 1'b0;
    for (int c = 0; c < 20 && !ram_we; c++) begin
      @(posedge clk); #1;
    end
    check("we_reached", ram_we, 1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("async_we_drop", ram_we, 0);
    check("async_busy", busy, 0);
    check("async_best", best_score, 0);
    check("async_done", done, 0);
    @(negedge clk); #1;
    check("abort_slot0", mem[0], 0);
    check("abort_writes", wr_cnt - w0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
